// File: rtl/conv_window_sequencer.sv
// Read-side sequencer for the feature-map buffer: walks every KxK stride-1
// window of a WxH row-major image and emits data-aligned valid/first/last markers.
module conv_window_sequencer #(
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned DIM_WIDTH  = 8,
    parameter int unsigned KERNEL     = 3
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [DIM_WIDTH-1:0]  i_img_width,
    input  logic [DIM_WIDTH-1:0]  i_img_height,
    input  logic                  i_stall,
    output logic                  o_read_en,
    output logic [ADDR_WIDTH-1:0] o_read_addr,
    output logic                  o_data_valid,
    output logic                  o_window_first,
    output logic                  o_window_last,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [DIM_WIDTH-1:0]  K_DIM  = DIM_WIDTH'(KERNEL);
    localparam logic [DIM_WIDTH-1:0]  K_LAST = DIM_WIDTH'(KERNEL - 1);
    localparam logic [ADDR_WIDTH-1:0] K_ADDR = ADDR_WIDTH'(KERNEL);

    logic [1:0]            state, state_next;
    logic [DIM_WIDTH-1:0]  w_q, h_q;
    logic [DIM_WIDTH-1:0]  orow, ocol, kr, kc;
    logic [ADDR_WIDTH-1:0] base, row_off;

    logic dims_ok, accept, issue;
    logic kc_wrap, kr_wrap, ocol_wrap, orow_wrap, last_elem;

    assign dims_ok   = (i_img_width >= K_DIM) && (i_img_height >= K_DIM);
    assign accept    = (state == S_IDLE) && i_start;
    assign issue     = (state == S_RUN) && !i_stall;
    assign kc_wrap   = (kc == K_LAST);
    assign kr_wrap   = (kr == K_LAST);
    assign ocol_wrap = (ocol == (w_q - K_DIM));
    assign orow_wrap = (orow == (h_q - K_DIM));
    assign last_elem = kc_wrap && kr_wrap && ocol_wrap && orow_wrap;

    // Read port is driven combinationally so a stall suppresses the read in the same cycle.
    assign o_read_en   = issue;
    assign o_read_addr = issue ? (base + row_off + ADDR_WIDTH'(kc)) : '0;

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= S_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (i_start) state_next = dims_ok ? S_RUN : S_DONE;
            S_RUN:   if (issue && last_elem) state_next = S_DRAIN;
            S_DRAIN: state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            w_q <= '0;
            h_q <= '0;
        end else if (accept) begin
            w_q <= i_img_width;
            h_q <= i_img_height;
        end
    end

    // Carry chain kc -> kr -> ocol -> orow; base tracks orow*W+ocol, row_off tracks kr*W.
    always_ff @(posedge i_clk) begin
        if (i_reset || accept) begin
            kc      <= '0;
            kr      <= '0;
            ocol    <= '0;
            orow    <= '0;
            base    <= '0;
            row_off <= '0;
        end else if (issue) begin
            if (kc_wrap) begin
                kc <= '0;
                if (kr_wrap) begin
                    kr      <= '0;
                    row_off <= '0;
                    if (ocol_wrap) begin
                        ocol <= '0;
                        if (orow_wrap) begin
                            orow <= '0;
                            base <= '0;
                        end else begin
                            orow <= orow + DIM_WIDTH'(1);
                            base <= base + K_ADDR;
                        end
                    end else begin
                        ocol <= ocol + DIM_WIDTH'(1);
                        base <= base + ADDR_WIDTH'(1);
                    end
                end else begin
                    kr      <= kr + DIM_WIDTH'(1);
                    row_off <= row_off + ADDR_WIDTH'(w_q);
                end
            end else begin
                kc <= kc + DIM_WIDTH'(1);
            end
        end
    end

    // Markers trail the read by one cycle to line up with the buffer's registered output.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_data_valid   <= 1'b0;
            o_window_first <= 1'b0;
            o_window_last  <= 1'b0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_error        <= 1'b0;
        end else begin
            o_data_valid   <= issue;
            o_window_first <= issue && (kr == '0) && (kc == '0);
            o_window_last  <= issue && kr_wrap && kc_wrap;
            o_busy         <= (state_next == S_RUN) || (state_next == S_DRAIN);
            o_done         <= (state_next == S_DONE);
            o_error        <= accept && !dims_ok;
        end
    end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Directed bench for conv_window_sequencer: address order, markers, stall, reset abort,
// undersized images and the K=1 degenerate case.
module tb_conv_window_sequencer;

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, start_k1, stall;
    logic [DW-1:0] width, height;

    logic          read_en, dv, wf, wl, busy, done, err;
    logic [AW-1:0] read_addr;
    logic          read_en1, dv1, wf1, wl1, busy1, done1, err1;
    logic [AW-1:0] read_addr1;

    conv_window_sequencer #(.DEPTH(64), .ADDR_WIDTH(AW), .DIM_WIDTH(DW), .KERNEL(3)) dut (
        .i_clk(clk), .i_reset(rst), .i_start(start),
        .i_img_width(width), .i_img_height(height), .i_stall(stall),
        .o_read_en(read_en), .o_read_addr(read_addr), .o_data_valid(dv),
        .o_window_first(wf), .o_window_last(wl), .o_busy(busy),
        .o_done(done), .o_error(err)
    );

    conv_window_sequencer #(.DEPTH(64), .ADDR_WIDTH(AW), .DIM_WIDTH(DW), .KERNEL(1)) dut_k1 (
        .i_clk(clk), .i_reset(rst), .i_start(start_k1),
        .i_img_width(width), .i_img_height(height), .i_stall(stall),
        .o_read_en(read_en1), .o_read_addr(read_addr1), .o_data_valid(dv1),
        .o_window_first(wf1), .o_window_last(wl1), .o_busy(busy1),
        .o_done(done1), .o_error(err1)
    );

    // Buffer model preloaded with data == address, 1-cycle registered read.
    logic [AW-1:0] mem [0:63];
    logic [AW-1:0] rdata;
    always @(posedge clk) if (read_en) rdata <= mem[read_addr];

    int checks = 0;
    int failures = 0;

    int addr_q[$];
    int data_q[$];
    int first_q[$];
    int last_q[$];
    int exp_q[$];
    int done_n, stalled_reads, busy_gaps;
    bit err_at_done, timed_out;

    task automatic build_model(input int w, input int h, input int k);
        exp_q.delete();
        for (int orow = 0; orow <= h - k; orow++)
            for (int ocol = 0; ocol <= w - k; ocol++)
                for (int kr = 0; kr < k; kr++)
                    for (int kc = 0; kc < k; kc++)
                        exp_q.push_back((orow + kr) * w + ocol + kc);
    endtask

    // Starts a scan on the K=3 unit and records reads/data until o_done or a cycle budget.
    task automatic capture_scan(input int w, input int h, input int stall_pct, input int restart_n);
        addr_q.delete(); data_q.delete(); first_q.delete(); last_q.delete();
        done_n = 0; stalled_reads = 0; busy_gaps = 0; err_at_done = 0; timed_out = 0;
        for (int n = 1; n <= 3000; n++) begin
            @(negedge clk);
            start  = (n == 1) || (n == restart_n);
            width  = (n == 1) ? DW'(w) : DW'(6);
            height = (n == 1) ? DW'(h) : DW'(6);
            stall  = (n > 1 && stall_pct > 0) ? ($urandom_range(99) < stall_pct) : 1'b0;
            #1;
            if (read_en) begin
                addr_q.push_back(int'(read_addr));
                if (stall) stalled_reads++;
            end
            if (dv) begin
                data_q.push_back(int'(rdata));
                first_q.push_back(int'(wf));
                last_q.push_back(int'(wl));
            end
            if (n > 1 && !done && !busy) busy_gaps++;
            if (done) begin
                done_n = n;
                err_at_done = err;
                break;
            end
        end
        if (done_n == 0) timed_out = 1;
        start = 1'b0;
        stall = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start_k1 = 1'b0; stall = 1'b0; width = '0; height = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({read_en, dv, wf, wl, busy, done, err} !== 7'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 0000000", {read_en, dv, wf, wl, busy, done, err});
        end
        checks++;
        if (read_addr !== '0) begin
            failures++;
            $display("FAIL reset_addr: got %0d expected 0", read_addr);
        end
        checks++;
        if ({read_en1, dv1, wf1, wl1, busy1, done1, err1} !== 7'b0) begin
            failures++;
            $display("FAIL reset_flags_k1: got %b expected 0000000", {read_en1, dv1, wf1, wl1, busy1, done1, err1});
        end
    endtask

    task automatic test_basic_4x4();
        int w0[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        int w3[9] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
        int nlast;
        capture_scan(4, 4, 0, 0);
        build_model(4, 4, 3);
        checks++;
        if (timed_out || addr_q.size() != 36) begin
            failures++;
            $display("FAIL basic_read_count: got %0d expected 36 (timeout=%0d)", addr_q.size(), timed_out);
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (addr_q[i] != w0[i]) begin
                    failures++;
                    $display("FAIL basic_win0[%0d]: got %0d expected %0d", i, addr_q[i], w0[i]);
                end
                checks++;
                if (addr_q[27 + i] != w3[i]) begin
                    failures++;
                    $display("FAIL basic_win3[%0d]: got %0d expected %0d", i, addr_q[27 + i], w3[i]);
                end
            end
            checks++;
            if (addr_q[9] != 1) begin
                failures++;
                $display("FAIL basic_win1_start: got %0d expected 1", addr_q[9]);
            end
        end
        nlast = 0;
        foreach (last_q[i]) nlast += last_q[i];
        checks++;
        if (nlast != 4) begin
            failures++;
            $display("FAIL basic_last_pulses: got %0d expected 4", nlast);
        end
        checks++;
        if (done_n != 39) begin
            failures++;
            $display("FAIL basic_done_latency: got %0d expected 39", done_n);
        end
        checks++;
        if (err_at_done !== 1'b0) begin
            failures++;
            $display("FAIL basic_error: got %0d expected 0", err_at_done);
        end
    endtask

    task automatic test_data_markers();
        capture_scan(4, 4, 0, 0);
        build_model(4, 4, 3);
        checks++;
        if (data_q.size() != 36) begin
            failures++;
            $display("FAIL data_count: got %0d expected 36", data_q.size());
        end else begin
            for (int i = 0; i < 36; i++) begin
                checks++;
                if (data_q[i] != exp_q[i] || first_q[i] != int'(i % 9 == 0) || last_q[i] != int'(i % 9 == 8)) begin
                    failures++;
                    $display("FAIL data_elem[%0d]: got data=%0d first=%0d last=%0d expected data=%0d first=%0d last=%0d",
                             i, data_q[i], first_q[i], last_q[i], exp_q[i], int'(i % 9 == 0), int'(i % 9 == 8));
                end
            end
        end
    endtask

    task automatic test_stall();
        capture_scan(5, 4, 30, 0);
        build_model(5, 4, 3);
        checks++;
        if (timed_out || addr_q.size() != 54) begin
            failures++;
            $display("FAIL stall_read_count: got %0d expected 54 (timeout=%0d)", addr_q.size(), timed_out);
        end else begin
            for (int i = 0; i < 54; i++) begin
                checks++;
                if (addr_q[i] != exp_q[i]) begin
                    failures++;
                    $display("FAIL stall_addr[%0d]: got %0d expected %0d", i, addr_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (stalled_reads != 0) begin
            failures++;
            $display("FAIL stall_read_while_stalled: got %0d expected 0", stalled_reads);
        end
        checks++;
        if (busy_gaps != 0) begin
            failures++;
            $display("FAIL stall_busy_gaps: got %0d expected 0", busy_gaps);
        end
    endtask

    task automatic test_too_small();
        capture_scan(2, 4, 0, 0);
        checks++;
        if (addr_q.size() != 0) begin
            failures++;
            $display("FAIL small_reads: got %0d expected 0", addr_q.size());
        end
        checks++;
        if (done_n != 2 || err_at_done !== 1'b1) begin
            failures++;
            $display("FAIL small_done_error: got done_n=%0d err=%0d expected done_n=2 err=1", done_n, err_at_done);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({done, err, busy, read_en} !== 4'b0) begin
            failures++;
            $display("FAIL small_back_to_idle: got %b expected 0000", {done, err, busy, read_en});
        end
    endtask

    task automatic test_reset_mid();
        int reads = 0;
        int bad = 0;
        @(negedge clk);
        start = 1'b1; width = 8'd4; height = 8'd4;
        for (int n = 0; n < 100 && reads < 10; n++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (read_en) reads++;
        end
        checks++;
        if (reads != 10) begin
            failures++;
            $display("FAIL abort_reads_before_reset: got %0d expected 10", reads);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({read_en, dv, wf, wl, busy, done, err} !== 7'b0 || read_addr !== '0) begin
            failures++;
            $display("FAIL abort_outputs: got %b addr=%0d expected 0000000 addr=0",
                     {read_en, dv, wf, wl, busy, done, err}, read_addr);
        end
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            #1;
            if (done || read_en) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL abort_no_done: got %0d active cycles expected 0", bad);
        end
        capture_scan(4, 4, 0, 0);
        checks++;
        if (addr_q.size() != 36 || addr_q[0] != 0) begin
            failures++;
            $display("FAIL abort_rescan: got count=%0d first=%0d expected count=36 first=0",
                     addr_q.size(), (addr_q.size() > 0) ? addr_q[0] : -1);
        end
    endtask

    task automatic test_start_ignored();
        int mism = 0;
        capture_scan(4, 4, 0, 10);
        build_model(4, 4, 3);
        checks++;
        if (addr_q.size() != 36) begin
            failures++;
            $display("FAIL restart_count: got %0d expected 36", addr_q.size());
        end else begin
            foreach (exp_q[i]) if (addr_q[i] != exp_q[i]) mism++;
            checks++;
            if (mism != 0) begin
                failures++;
                $display("FAIL restart_addrs: got %0d mismatched addresses expected 0", mism);
            end
        end
        checks++;
        if (done_n != 39) begin
            failures++;
            $display("FAIL restart_latency: got %0d expected 39", done_n);
        end
    endtask

    task automatic test_k1();
        int a_q[$];
        int flag_bad = 0;
        int ndv = 0;
        int dn = 0;
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            start_k1 = (n == 1);
            width = 8'd3; height = 8'd2;
            #1;
            if (read_en1) a_q.push_back(int'(read_addr1));
            if (dv1) begin
                ndv++;
                if (!(wf1 && wl1)) flag_bad++;
            end
            if (done1) begin
                dn = n;
                break;
            end
        end
        start_k1 = 1'b0;
        checks++;
        if (a_q.size() != 6) begin
            failures++;
            $display("FAIL k1_count: got %0d expected 6", a_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (a_q[i] != i) begin
                    failures++;
                    $display("FAIL k1_addr[%0d]: got %0d expected %0d", i, a_q[i], i);
                end
            end
        end
        checks++;
        if (ndv != 6 || flag_bad != 0) begin
            failures++;
            $display("FAIL k1_markers: got valid=%0d unflagged=%0d expected valid=6 unflagged=0", ndv, flag_bad);
        end
        checks++;
        if (dn != 9) begin
            failures++;
            $display("FAIL k1_latency: got %0d expected 9", dn);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = AW'(i);
        test_reset();
        test_basic_4x4();
        test_data_markers();
        test_stall();
        test_too_small();
        test_reset_mid();
        test_start_ignored();
        test_k1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
